// File: rtl/msrv32_ahb_pkg.sv
// msrv32_ahb_pkg: shared AHB-Lite encodings and FSM state type
// for the data-memory AHB master and its size decoder.
package msrv32_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR  = 3'd3,
        ST_DONE = 3'd4
    } dmem_state_e;

    // Latched core request
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic [2:0]  size;
        logic        illegal;
    } dmem_req_t;

endpackage

// File: rtl/msrv32_ahb_size_dec.sv
// msrv32_ahb_size_dec: byte-mask to HSIZE / address offset decoder.
// Ports: i_mask (write strobes) -> o_hsize, o_offset, o_illegal.
module msrv32_ahb_size_dec
    import msrv32_ahb_pkg::*;
(
    input  logic [3:0] i_mask,
    output logic [2:0] o_hsize,
    output logic [1:0] o_offset,
    output logic       o_illegal
);

    // Offset is the lowest set strobe; for every legal mask this
    // is the first byte lane of the access.
    always_comb begin
        o_offset = 2'd0;
        if (i_mask[0])
            o_offset = 2'd0;
        else if (i_mask[1])
            o_offset = 2'd1;
        else if (i_mask[2])
            o_offset = 2'd2;
        else if (i_mask[3])
            o_offset = 2'd3;
    end

    always_comb begin
        o_hsize   = HSIZE_WORD;
        o_illegal = 1'b0;
        unique case (i_mask)
            4'b1111: o_hsize = HSIZE_WORD;
            4'b0011,
            4'b1100: o_hsize = HSIZE_HALF;
            4'b0001,
            4'b0010,
            4'b0100,
            4'b1000: o_hsize = HSIZE_BYTE;
            default: begin
                o_hsize   = HSIZE_WORD;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/msrv32_dmem_ahb_master.sv
// msrv32_dmem_ahb_master: bridges the core data-memory port to an
// AHB-Lite master (single NONSEQ transfers, wait states, ERROR).
// Ports: ms_riscv32_mp_clk_in/rst_in (sync active-high reset);
//   core side: core_addr_in, core_wdata_in, core_wr_req_in,
//   core_wr_mask_in, core_htrans_in -> core_rdata_out,
//   core_hready_out, core_hresp_out;
//   bus side: haddr/htrans/hwrite/hsize/hburst/hprot/hwdata outs,
//   hrdata_in, hready_in, hresp_in.
// Optional: MSRV32_DMEM_ERR_CAPTURE_EN adds err_addr_out/err_wr_out.
module msrv32_dmem_ahb_master
    import msrv32_ahb_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011,
    parameter int         ERR_HOLD  = 1
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [31:0] core_addr_in,
    input  logic [31:0] core_wdata_in,
    input  logic        core_wr_req_in,
    input  logic [3:0]  core_wr_mask_in,
    input  logic [1:0]  core_htrans_in,
    output logic [31:0] core_rdata_out,
    output logic        core_hready_out,
    output logic        core_hresp_out,
    output logic [31:0] haddr_out,
    output logic [1:0]  htrans_out,
    output logic        hwrite_out,
    output logic [2:0]  hsize_out,
    output logic [2:0]  hburst_out,
    output logic [3:0]  hprot_out,
    output logic [31:0] hwdata_out,
    input  logic [31:0] hrdata_in,
    input  logic        hready_in,
    input  logic        hresp_in
`ifdef MSRV32_DMEM_ERR_CAPTURE_EN
    ,
    output logic [31:0] err_addr_out,
    output logic        err_wr_out
`endif
);

    localparam logic [1:0] LP_HOLD = 2'(ERR_HOLD);

    dmem_state_e r_state;
    dmem_state_e w_next;
    dmem_req_t   r_req;
    dmem_req_t   w_new_req;
    logic [31:0] r_rdata;
    logic [1:0]  r_hold;

    logic        w_ready;
    logic        w_accept;
    logic        w_set_err;
    logic        w_ok;
    logic [2:0]  w_dec_size;
    logic [1:0]  w_dec_off;
    logic        w_dec_ill;

    msrv32_ahb_size_dec u_size_dec (
        .i_mask    (core_wr_mask_in),
        .o_hsize   (w_dec_size),
        .o_offset  (w_dec_off),
        .o_illegal (w_dec_ill)
    );

    assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_accept = w_ready && (core_htrans_in == HTRANS_NONSEQ);

    // Reads are always word-aligned words; the load unit picks lanes.
    // An illegal write keeps the raw core address so the error
    // record shows what the core actually asked for.
    always_comb begin
        w_new_req.wdata   = core_wdata_in;
        w_new_req.write   = core_wr_req_in;
        w_new_req.size    = HSIZE_WORD;
        w_new_req.illegal = 1'b0;
        w_new_req.addr    = {core_addr_in[31:2], 2'b00};
        if (core_wr_req_in) begin
            w_new_req.size    = w_dec_size;
            w_new_req.illegal = w_dec_ill;
            if (w_dec_ill)
                w_new_req.addr = core_addr_in;
            else
                w_new_req.addr = {core_addr_in[31:2], w_dec_off};
        end
    end

    always_comb begin
        w_next    = r_state;
        w_set_err = 1'b0;
        w_ok      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept)
                    w_next = ST_ADDR;
            end
            ST_ADDR: begin
                // Illegal mask: complete with error, nothing on the bus
                if (r_req.illegal) begin
                    w_next    = ST_DONE;
                    w_set_err = 1'b1;
                end else if (hready_in) begin
                    w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (hresp_in) begin
                    if (hready_in) begin
                        w_next    = ST_DONE;
                        w_set_err = 1'b1;
                    end else begin
                        w_next = ST_ERR;
                    end
                end else if (hready_in) begin
                    w_next = ST_DONE;
                    w_ok   = 1'b1;
                end
            end
            ST_ERR: begin
                if (hready_in) begin
                    w_next    = ST_DONE;
                    w_set_err = 1'b1;
                end
            end
            ST_DONE: begin
                w_next = w_accept ? ST_ADDR : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_state       <= ST_IDLE;
            r_req.addr    <= '0;
            r_req.wdata   <= '0;
            r_req.write   <= 1'b0;
            r_req.size    <= HSIZE_WORD;
            r_req.illegal <= 1'b0;
            r_rdata       <= '0;
            r_hold        <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept)
                r_req <= w_new_req;
            if (w_ok && !r_req.write)
                r_rdata <= hrdata_in;
            // Error flag visible from DONE for ERR_HOLD cycles
            if (w_set_err)
                r_hold <= LP_HOLD;
            else if (r_hold != 2'd0)
                r_hold <= r_hold - 2'd1;
        end
    end

`ifdef MSRV32_DMEM_ERR_CAPTURE_EN
    logic [31:0] r_err_addr;
    logic        r_err_wr;

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_err_addr <= '0;
            r_err_wr   <= 1'b0;
        end else if (w_set_err) begin
            r_err_addr <= r_req.addr;
            r_err_wr   <= r_req.write;
        end
    end

    assign err_addr_out = r_err_addr;
    assign err_wr_out   = r_err_wr;
`endif

    assign htrans_out = ((r_state == ST_ADDR) && !r_req.illegal)
                        ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr_out       = r_req.addr;
    assign hwrite_out      = r_req.write;
    assign hsize_out       = r_req.size;
    assign hwdata_out      = r_req.wdata;
    assign hburst_out      = HBURST_SINGLE;
    assign hprot_out       = HPROT_VAL;
    assign core_rdata_out  = r_rdata;
    assign core_hready_out = w_ready;
    assign core_hresp_out  = (r_hold != 2'd0);

endmodule

// File: tb/tb_msrv32_dmem_ahb_master.sv
// tb_msrv32_dmem_ahb_master: directed AHB transfers with a
// completion scoreboard for read data and error response.
module tb_msrv32_dmem_ahb_master;

    localparam int ERR_HOLD = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] core_addr_in = '0;
    logic [31:0] core_wdata_in = '0;
    logic        core_wr_req_in = 1'b0;
    logic [3:0]  core_wr_mask_in = '0;
    logic [1:0]  core_htrans_in = 2'b00;
    logic [31:0] core_rdata_out;
    logic        core_hready_out;
    logic        core_hresp_out;
    logic [31:0] haddr_out;
    logic [1:0]  htrans_out;
    logic        hwrite_out;
    logic [2:0]  hsize_out;
    logic [2:0]  hburst_out;
    logic [3:0]  hprot_out;
    logic [31:0] hwdata_out;
    logic [31:0] hrdata_in = 32'h0BAD_F00D;
    logic        hready_in = 1'b1;
    logic        hresp_in = 1'b0;
`ifdef MSRV32_DMEM_ERR_CAPTURE_EN
    logic [31:0] err_addr_out;
    logic        err_wr_out;
`endif

    always #5 clk = ~clk;

    msrv32_dmem_ahb_master #(
        .HPROT_VAL (4'b0011),
        .ERR_HOLD  (ERR_HOLD)
    ) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .core_addr_in         (core_addr_in),
        .core_wdata_in        (core_wdata_in),
        .core_wr_req_in       (core_wr_req_in),
        .core_wr_mask_in      (core_wr_mask_in),
        .core_htrans_in       (core_htrans_in),
        .core_rdata_out       (core_rdata_out),
        .core_hready_out      (core_hready_out),
        .core_hresp_out       (core_hresp_out),
        .haddr_out            (haddr_out),
        .htrans_out           (htrans_out),
        .hwrite_out           (hwrite_out),
        .hsize_out            (hsize_out),
        .hburst_out           (hburst_out),
        .hprot_out            (hprot_out),
        .hwdata_out           (hwdata_out),
        .hrdata_in            (hrdata_in),
        .hready_in            (hready_in),
        .hresp_in             (hresp_in)
`ifdef MSRV32_DMEM_ERR_CAPTURE_EN
        ,
        .err_addr_out         (err_addr_out),
        .err_wr_out           (err_wr_out)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    logic mon_prev = 1'b1;
    int   hold_cnt = 0;

    // Completion = core_hready_out rising after a busy cycle
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            mon_prev = 1'b1;
            hold_cnt = 0;
        end else begin
            if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0)
                    chk("hresp_release", core_hresp_out, 0);
            end
            if (!mon_prev && core_hready_out) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got completion want none");
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_rdata", core_rdata_out, e.rdata);
                    chk("sb_hresp", core_hresp_out, 32'(e.err));
                    if (e.err)
                        hold_cnt = ERR_HOLD;
                end
            end
            mon_prev = core_hready_out;
        end
    end

    task automatic xfer(
        input string       nm,
        input logic [31:0] addr,
        input logic [31:0] wd,
        input logic        wr,
        input logic [3:0]  mask,
        input int          waits,
        input logic        berr,
        input logic [31:0] brd,
        input logic [31:0] e_haddr,
        input logic [2:0]  e_size,
        input logic        ill,
        input logic [31:0] e_rdata
    );
        exp_t e;
        int guard = 0;
        while (!core_hready_out && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            total++;
            bad++;
            $display("FAIL %s.ready_timeout: got busy want ready", nm);
            return;
        end
        e.rdata = e_rdata;
        e.err   = ill | berr;
        sb_q.push_back(e);
        core_addr_in    = addr;
        core_wdata_in   = wd;
        core_wr_req_in  = wr;
        core_wr_mask_in = mask;
        core_htrans_in  = 2'b10;
        @(negedge clk);
        core_htrans_in = 2'b00;
        chk({nm, ".htrans_a"}, htrans_out, ill ? 0 : 2);
        chk({nm, ".rdy_a"}, core_hready_out, 0);
        if (ill) begin
            @(negedge clk);
            return;
        end
        chk({nm, ".haddr"}, haddr_out, e_haddr);
        chk({nm, ".hsize"}, hsize_out, e_size);
        chk({nm, ".hwrite"}, hwrite_out, wr);
        @(negedge clk);
        chk({nm, ".htrans_d"}, htrans_out, 0);
        if (wr)
            chk({nm, ".hwdata"}, hwdata_out, wd);
        for (int i = 0; i < waits; i++) begin
            hready_in = 1'b0;
            @(negedge clk);
            chk({nm, ".rdy_w"}, core_hready_out, 0);
        end
        if (berr) begin
            hready_in = 1'b0;
            hresp_in  = 1'b1;
            @(negedge clk);
            chk({nm, ".htrans_e"}, htrans_out, 0);
            hready_in = 1'b1;
            @(negedge clk);
            hresp_in = 1'b0;
        end else begin
            hrdata_in = brd;
            hready_in = 1'b1;
            @(negedge clk);
            hrdata_in = 32'h0BAD_F00D;
        end
        chk({nm, ".rdy_done"}, core_hready_out, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst.htrans", htrans_out, 0);
        chk("rst.haddr", haddr_out, 0);
        chk("rst.hwrite", hwrite_out, 0);
        chk("rst.hsize", hsize_out, 3'b010);
        chk("rst.hwdata", hwdata_out, 0);
        chk("rst.rdata", core_rdata_out, 0);
        chk("rst.hready", core_hready_out, 1);
        chk("rst.hresp", core_hresp_out, 0);
        chk("rst.hburst", hburst_out, 0);
        chk("rst.hprot", hprot_out, 4'b0011);
        rst = 1'b0;
        @(negedge clk);

        xfer("rd0", 32'h0000_1006, 32'h0, 1'b0, 4'b0000, 0, 1'b0,
             32'hDEAD_BEEF, 32'h0000_1004, 3'b010, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        xfer("wbyte", 32'h0000_2000, 32'h00AB_0000, 1'b1, 4'b0100, 0,
             1'b0, 32'h0, 32'h0000_2002, 3'b000, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        xfer("whalf", 32'h0000_3000, 32'h1234_0000, 1'b1, 4'b1100, 3,
             1'b0, 32'h0, 32'h0000_3002, 3'b001, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("whalf.one_cycle", core_hready_out, 1);
        xfer("rderr", 32'h0000_4008, 32'h0, 1'b0, 4'b0000, 0, 1'b1,
             32'h0, 32'h0000_4008, 3'b010, 1'b0, 32'hDEAD_BEEF);
`ifdef MSRV32_DMEM_ERR_CAPTURE_EN
        chk("cap.addr", err_addr_out, 32'h0000_4008);
        chk("cap.wr", err_wr_out, 0);
`endif
        @(negedge clk);
        xfer("wword", 32'h0000_5000, 32'hCAFE_F00D, 1'b1, 4'b1111, 0,
             1'b0, 32'h0, 32'h0000_5000, 3'b010, 1'b0, 32'hDEAD_BEEF);
        xfer("b2b_rd", 32'h0000_6000, 32'h0, 1'b0, 4'b0000, 1, 1'b0,
             32'h1122_3344, 32'h0000_6000, 3'b010, 1'b0, 32'h1122_3344);
        xfer("ill", 32'h0000_7000, 32'h5555_5555, 1'b1, 4'b0101, 0,
             1'b0, 32'h0, 32'h0, 3'b010, 1'b1, 32'h1122_3344);
        @(negedge clk);
        @(negedge clk);
        xfer("wb3", 32'h0000_8001, 32'h7700_0000, 1'b1, 4'b1000, 0,
             1'b0, 32'h0, 32'h0000_8003, 3'b000, 1'b0, 32'h1122_3344);
        @(negedge clk);
        xfer("wh0", 32'h0000_9002, 32'h0000_BEEF, 1'b1, 4'b0011, 2,
             1'b0, 32'h0, 32'h0000_9000, 3'b001, 1'b0, 32'h1122_3344);
        @(negedge clk);

        core_addr_in    = 32'h0000_B000;
        core_wr_req_in  = 1'b0;
        core_wr_mask_in = 4'b0000;
        core_htrans_in  = 2'b10;
        @(negedge clk);
        core_htrans_in = 2'b00;
        @(negedge clk);
        hready_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst.htrans", htrans_out, 0);
        chk("mrst.hready", core_hready_out, 1);
        chk("mrst.hresp", core_hresp_out, 0);
        chk("mrst.haddr", haddr_out, 0);
        chk("mrst.rdata", core_rdata_out, 0);
`ifdef MSRV32_DMEM_ERR_CAPTURE_EN
        chk("mrst.err_addr", err_addr_out, 0);
`endif
        @(negedge clk);
        rst       = 1'b0;
        hready_in = 1'b1;
        @(negedge clk);

        xfer("post_rd", 32'h0000_A000, 32'h0, 1'b0, 4'b0000, 0, 1'b0,
             32'h55AA_55AA, 32'h0000_A000, 3'b010, 1'b0, 32'h55AA_55AA);
        repeat (4) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msrv32_dmem_ahb_master.md
Name: msrv32_dmem_ahb_master

Overview:
- Bridges the core's data-memory port (address, write data, write request, byte mask, htrans) onto an AHB-Lite master bus.
- Sits directly downstream of msrv32_top's data-memory interface.
- Returns read data, a ready/stall signal and an error response to the core.
- Registers each request and runs a proper address/data phase, including wait states and the two-cycle ERROR response.

Parameters:
- HPROT_VAL, 4'b0011, value driven on HPROT (non-cacheable, non-bufferable, privileged data access).
- ERR_HOLD, 1, number of cycles core_hresp_out stays high after an error completes (1 to 3).

Ports:
- ms_riscv32_mp_clk_in  in  1  system clock
- ms_riscv32_mp_rst_in  in  1  synchronous active-high reset
- core_addr_in  in  32  byte address from the core store unit
- core_wdata_in  in  32  lane-aligned store data
- core_wr_req_in  in  1  1 = write, 0 = read
- core_wr_mask_in  in  4  byte strobes for writes (ignored for reads)
- core_htrans_in  in  2  2'b10 = request valid, anything else = idle
- core_rdata_out  out  32  read data returned to the core
- core_hready_out  out  1  1 = previous transfer done and new request accepted
- core_hresp_out  out  1  error flag to the core
- haddr_out  out  32  AHB HADDR
- htrans_out  out  2  AHB HTRANS (IDLE 2'b00 / NONSEQ 2'b10 only)
- hwrite_out  out  1  AHB HWRITE
- hsize_out  out  3  AHB HSIZE
- hburst_out  out  3  fixed 3'b000 (SINGLE)
- hprot_out  out  4  HPROT_VAL
- hwdata_out  out  32  AHB HWDATA, valid during the write data phase
- hrdata_in  in  32  AHB HRDATA
- hready_in  in  1  AHB HREADY
- hresp_in  in  1  AHB HRESP (1 = ERROR)

Behaviour:
- Clock and reset: one clock, ms_riscv32_mp_clk_in. Reset is synchronous, active-high, on ms_riscv32_mp_rst_in.
- Reset values:
  - FSM goes to IDLE.
  - htrans_out=00, haddr_out=0, hwrite_out=0, hsize_out=010, hwdata_out=0.
  - core_rdata_out=0, core_hready_out=1, core_hresp_out=0.
- FSM states:
  - IDLE: core_hready_out=1. A request is accepted when core_htrans_in==10 and core_hready_out==1. All request fields are latched and the FSM moves to ADDR.
  - ADDR: drives htrans_out=NONSEQ, haddr_out, hwrite_out, hsize_out; core_hready_out=0. When hready_in=1 the FSM moves to DATA, otherwise it stays.
  - DATA: htrans_out=IDLE; hwdata_out holds the latched write data.
    - hready_in=1 and hresp_in=0: OK completion. Move to DONE.
    - hready_in=0 and hresp_in=1: first error cycle. Move to ERR.
    - hready_in=0 and hresp_in=0: wait state. Stay in DATA.
  - ERR: htrans_out=IDLE. When hready_in=1, move to DONE with the error flag set.
  - DONE: core_hready_out=1 for exactly one cycle. For a read, core_rdata_out holds the captured HRDATA. If the error flag is set, core_hresp_out is asserted for ERR_HOLD cycles. A new request accepted in this cycle goes to ADDR; otherwise the FSM goes to IDLE.
- Latency: request accepted at cycle N gives the address phase at N+1 and the earliest data phase at N+2. Completion (core_hready_out=1) is at N+3 plus wait states.
- HSIZE derivation:
  - Reads: always a word. haddr_out = {addr[31:2],2'b00}, hsize=010. The core's load unit extracts the byte/half lanes.
  - Writes, by mask: 1111 gives word (010); 0011 or 1100 gives half (001); a single bit gives byte (000).
  - Write address is {addr[31:2], offset}, where offset is the lowest set mask bit.
  - Any other mask value gives hsize=010 and the error flag is raised without issuing a bus transfer (ADDR→DONE directly).
- Requests while busy: core_hready_out=0, so the request is ignored. The core holds its request.
- hrdata_in is captured only on the OK completion edge. core_rdata_out is unchanged on writes and on errors.
- Reset asserted mid-transfer: immediate return to IDLE with reset output values. Any outstanding bus transfer is abandoned.

Optional Feature:
- MSRV32_DMEM_ERR_CAPTURE_EN: when defined, adds two outputs:
  - err_addr_out[31:0]: latches the address of the most recent errored transfer. Reset value 0.
  - err_wr_out: latches its write flag. Reset value 0.
  - When undefined, neither port nor its registers exist.

Decomposition:
- Shared package msrv32_ahb_pkg holds:
  - HTRANS_IDLE/NONSEQ
  - HSIZE_BYTE/HALF/WORD
  - HBURST_SINGLE
  - the FSM state encoding (IDLE, ADDR, DATA, ERR, DONE)
- One sub-module, msrv32_ahb_size_dec: combinational mask→{hsize, addr offset, illegal}.

Test Plan:
- Read 0x0000_1006 with zero wait states: haddr=0x0000_1004, hsize=010, hwrite=0 at N+1. HRDATA=0xDEADBEEF gives core_rdata_out=0xDEADBEEF with core_hready_out=1 at N+3.
- Byte write, mask 0100, addr 0x2000, data 0x00AB0000: haddr=0x2002, hsize=000, hwrite=1. hwdata=0x00AB0000 in the data phase.
- Half write, mask 1100, with 3 wait states: core_hready_out stays 0 until N+6, then goes to 1 for one cycle.
- Error response: hresp=1/hready=0 then hresp=1/hready=1. htrans stays IDLE in both cycles, core_hresp_out=1 for ERR_HOLD cycles, core_rdata_out unchanged.
- Back-to-back: new request presented in DONE gives an address phase the very next cycle with no IDLE gap. Also, mask 0101 gives an error with no NONSEQ on the bus.
- Reset asserted during DATA with wait states: next cycle htrans=00, core_hready_out=1, FSM in IDLE. Under MSRV32_DMEM_ERR_CAPTURE_EN, err_addr_out=0.
